axis_pattern_bram_writer: RTL and testbench

//  Loads pulse-pattern waveforms into the dual-port pattern BRAM that the pulse-pattern player reads (write side).

---
 rtl/axis_pattern_bram_writer.sv | 117 +++++++++++
 tb/tb_axis_pattern_bram_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_bram_writer.sv
// Streams AXI-Stream samples into consecutive BRAM addresses from 0, counting complete
// pulses of (pulse_length+1) words and publishing the last address written.
module axis_pattern_bram_writer #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int BRAM_DATA_WIDTH  = 16,
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [2*BRAM_ADDR_WIDTH-1:0] cfg_data,
  input  logic                         arm,
  output logic                         done,
  output logic [BRAM_ADDR_WIDTH-1:0]   waveform_length,
  output logic [CNTR_WIDTH-1:0]        pulse_count,
  output logic [31:0]                  sts_data,
  output logic                         s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic                         bram_porta_we
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [BRAM_ADDR_WIDTH-1:0] pulse_length;
  logic [BRAM_ADDR_WIDTH-1:0] max_addr;
  logic [BRAM_ADDR_WIDTH-1:0] addr_cnt;
  logic [BRAM_ADDR_WIDTH-1:0] point;
  logic                       truncated;
  logic                       partial;
  logic                       hs;
  logic                       at_max;
  logic                       pulse_end;
  logic                       finish;
  logic                       start;

  assign pulse_length = cfg_data[BRAM_ADDR_WIDTH-1:0];
  assign max_addr     = cfg_data[2*BRAM_ADDR_WIDTH-1:BRAM_ADDR_WIDTH];

  // Handshake: a sample transfers on any rising edge where s_axis_tvalid and
  // s_axis_tready are both high; tready is only ever high in WRITE.
  assign hs        = s_axis_tvalid & s_axis_tready;
  assign at_max    = (addr_cnt == max_addr);
  assign pulse_end = (point == pulse_length);
  assign finish    = hs & (s_axis_tlast | at_max);
  assign start     = arm & (state != WRITE);

  assign done           = (state == DONE);
  assign bram_porta_clk = aclk;
  assign bram_porta_rst = ~aresetn;
  assign sts_data       = {16'(pulse_count), 12'b0, truncated, partial, state};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = WRITE;
      WRITE:   if (finish) state_next = DONE;
      DONE:    if (arm) state_next = WRITE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= IDLE;
      s_axis_tready     <= 1'b0;
      addr_cnt          <= '0;
      point             <= '0;
      pulse_count       <= '0;
      waveform_length   <= '0;
      truncated         <= 1'b0;
      partial           <= 1'b0;
      bram_porta_we     <= 1'b0;
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
    end else begin
      state         <= state_next;
      s_axis_tready <= (state_next == WRITE);
      bram_porta_we <= hs;
      if (start) begin
        addr_cnt    <= '0;
        point       <= '0;
        pulse_count <= '0;
        truncated   <= 1'b0;
        partial     <= 1'b0;
      end else if (hs) begin
        bram_porta_addr   <= addr_cnt;
        bram_porta_wrdata <= s_axis_tdata[BRAM_DATA_WIDTH-1:0];
        waveform_length   <= addr_cnt;
        // Hold at capacity so the address never wraps past max_addr.
        if (!at_max) addr_cnt <= addr_cnt + 1'b1;
        if (pulse_end) begin
          point <= '0;
          if (pulse_count != '1) pulse_count <= pulse_count + 1'b1;
        end else begin
          point <= point + 1'b1;
        end
        if (finish) begin
          truncated <= at_max & ~s_axis_tlast;
          partial   <= ~pulse_end;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pattern_bram_writer.sv
// Directed bench for axis_pattern_bram_writer: table of load scenarios plus a
// hand-written mid-stream reset sequence.
module tb_axis_pattern_bram_writer;

  logic        aclk;
  logic        aresetn;
  logic [31:0] cfg_data;
  logic        arm;
  logic        done;
  logic [15:0] waveform_length;
  logic [15:0] pulse_count;
  logic [31:0] sts_data;
  logic        s_axis_tready;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        bram_porta_clk;
  logic        bram_porta_rst;
  logic [15:0] bram_porta_addr;
  logic [15:0] bram_porta_wrdata;
  logic        bram_porta_we;

  axis_pattern_bram_writer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .cfg_data          (cfg_data),
    .arm               (arm),
    .done              (done),
    .waveform_length   (waveform_length),
    .pulse_count       (pulse_count),
    .sts_data          (sts_data),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_wrdata (bram_porta_wrdata),
    .bram_porta_we     (bram_porta_we)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] pl;
    logic [15:0] max_a;
    int          n;
    int          tlast_idx;
    bit          gap;
    int          arm_at;
    int          exp_writes;
    logic [15:0] exp_pc;
    logic [15:0] exp_wlen;
    bit          exp_trunc;
    bit          exp_part;
  } vec_t;

  vec_t tbl[9];

  // ---------------- driver ----------------
  task automatic run_load(input int k);
    vec_t v;
    int   i;
    int   writes;
    bit   hs;
    logic [31:0] e;
    v = tbl[k];
    exp_q.delete();
    i = 0;
    writes = 0;
    cfg_data = {v.max_a, v.pl};
    @(negedge aclk);
    arm = 1'b1;
    @(negedge aclk);
    arm = 1'b0;
    check($sformatf("s%0d_tready_after_arm", k), 32'(s_axis_tready), 32'd1);
    for (int cyc = 0; cyc < 2 * v.n + 4; cyc++) begin
      arm = (cyc == v.arm_at);
      if (i < v.n && !(v.gap && (cyc % 2 == 1))) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hA000 + 16'(k * 16 + i);
        s_axis_tlast  = (i == v.tlast_idx);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      hs = s_axis_tvalid & s_axis_tready;
      if (hs) exp_q.push_back({16'(i), s_axis_tdata});
      @(negedge aclk);
      arm = 1'b0;
      check($sformatf("s%0d_c%0d_we", k, cyc), 32'(bram_porta_we), 32'(hs));
      if (bram_porta_we) begin
        writes++;
        if (exp_q.size() == 0) begin
          check($sformatf("s%0d_c%0d_unexpected_write", k, cyc), 32'(bram_porta_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("s%0d_c%0d_addr_data", k, cyc), {bram_porta_addr, bram_porta_wrdata}, e);
        end
      end
      if (hs) i++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check($sformatf("s%0d_writes", k), 32'(writes), 32'(v.exp_writes));
    check($sformatf("s%0d_done", k), 32'(done), 32'd1);
    check($sformatf("s%0d_tready_idle", k), 32'(s_axis_tready), 32'd0);
    check($sformatf("s%0d_pulse_count", k), 32'(pulse_count), 32'(v.exp_pc));
    check($sformatf("s%0d_waveform_length", k), 32'(waveform_length), 32'(v.exp_wlen));
    check($sformatf("s%0d_sts", k), sts_data,
          {v.exp_pc, 12'b0, v.exp_trunc, v.exp_part, 2'd2});
  endtask

  // ---------------- test ----------------
  initial begin
    //           pl     max    n  tlast gap arm  wr  pc     wlen   tr part
    tbl[0] = '{16'd3, 16'd255, 8,  7,  0, -1, 8, 16'd2, 16'd7, 0, 0};
    tbl[1] = '{16'd3, 16'd255, 6,  5,  0, -1, 6, 16'd1, 16'd5, 0, 1};
    tbl[2] = '{16'd3, 16'd4,  10, -1,  0, -1, 5, 16'd1, 16'd4, 1, 1};
    tbl[3] = '{16'd1, 16'd255, 6,  5,  1, -1, 6, 16'd3, 16'd5, 0, 0};
    tbl[4] = '{16'd0, 16'd255, 3,  2,  0, -1, 3, 16'd3, 16'd2, 0, 0};
    tbl[5] = '{16'd1, 16'd3,   4,  3,  0, -1, 4, 16'd2, 16'd3, 0, 0};
    tbl[6] = '{16'd2, 16'd2,   5, -1,  0, -1, 3, 16'd1, 16'd2, 1, 0};
    tbl[7] = '{16'd1, 16'd255, 4,  3,  0,  2, 4, 16'd2, 16'd3, 0, 0};
    tbl[8] = '{16'd3, 16'd255, 4,  3,  0, -1, 4, 16'd1, 16'd3, 0, 0};

    aresetn       = 1'b0;
    cfg_data      = '0;
    arm           = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #12;
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_we", 32'(bram_porta_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sts", sts_data, 32'd0);
    check("rst_wlen", 32'(waveform_length), 32'd0);
    check("rst_addr_data", {bram_porta_addr, bram_porta_wrdata}, 32'd0);
    check("rst_bram_rst", 32'(bram_porta_rst), 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_tready", 32'(s_axis_tready), 32'd0);
    check("bram_rst_released", 32'(bram_porta_rst), 32'd0);

    for (int k = 0; k < 8; k++) run_load(k);

    // Mid-stream reset: words 0..3 offered back to back, reset right after word 3 lands.
    cfg_data = {16'd255, 16'd3};
    @(negedge aclk);
    arm = 1'b1;
    @(negedge aclk);
    arm = 1'b0;
    for (int w = 0; w < 4; w++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 16'h5500 + 16'(w);
      s_axis_tlast  = 1'b0;
      if (w < 3) @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    check("pre_rst_we", 32'(bram_porta_we), 32'd1);
    check("pre_rst_addr", 32'(bram_porta_addr), 32'd3);
    aresetn = 1'b0;
    #1;
    check("midrst_we", 32'(bram_porta_we), 32'd0);
    check("midrst_tready", 32'(s_axis_tready), 32'd0);
    check("midrst_sts", sts_data, 32'd0);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    run_load(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
